// File: rtl/fl_alloc_sched_if.sv
// Handshake bundle between the allocation/retire scheduler and its requesters and free list.
// Stats counters are present only when FL_SCHED_STATS_EN is defined.
interface fl_alloc_sched_if #(
    parameter int N_REQ      = 4,
    parameter int RET_W      = 2,
    parameter int PREG_IDX_W = 6
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            grant;
    logic [PREG_IDX_W-1:0]       grant_tag;
    logic                        fl_free_valid;
    logic [PREG_IDX_W-1:0]       fl_free_tag;
    logic                        fl_pop_en;
    logic [RET_W-1:0]            ret_valid;
    logic [RET_W*PREG_IDX_W-1:0] ret_tag;
    logic                        ret_ready;
    logic                        fl_retire_en;
    logic [PREG_IDX_W-1:0]       fl_retire_tag;
    logic                        flush_req;
    logic                        flush_done;
`ifdef FL_SCHED_STATS_EN
    logic [31:0]                 stat_grants;
    logic [31:0]                 stat_stalls;
`endif

    modport master (
        output req, fl_free_valid, fl_free_tag, ret_valid, ret_tag, flush_req,
`ifdef FL_SCHED_STATS_EN
        input  stat_grants, stat_stalls,
`endif
        input  grant, grant_tag, fl_pop_en, ret_ready, fl_retire_en, fl_retire_tag, flush_done
    );

    modport slave (
        input  req, fl_free_valid, fl_free_tag, ret_valid, ret_tag, flush_req,
`ifdef FL_SCHED_STATS_EN
        output stat_grants, stat_stalls,
`endif
        output grant, grant_tag, fl_pop_en, ret_ready, fl_retire_en, fl_retire_tag, flush_done
    );
endinterface

// File: rtl/fl_alloc_sched.sv
// Round-robin sharing of the free-list pop port plus a retire-tag FIFO feeding the retire port.
// Latency: grants are combinational (0 cycles); retire tags reach the free list >= 1 cycle after enqueue.
// Backpressure: ret_ready drops when fewer than RET_W entries are free; optional stats via FL_SCHED_STATS_EN.
module fl_alloc_sched #(
    parameter int N_REQ      = 4,
    parameter int RET_W      = 2,
    parameter int RET_DEPTH  = 8,
    parameter int PREG_IDX_W = 6
) (
    input logic              clock,
    input logic              reset,
    fl_alloc_sched_if.slave  bus
);
    localparam int RR_W  = $clog2(N_REQ);
    localparam int PTR_W = $clog2(RET_DEPTH);
    localparam int CNT_W = $clog2(RET_DEPTH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE, HOLD} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [RR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [PREG_IDX_W-1:0]   mem [RET_DEPTH];

    logic [N_REQ-1:0]        grant;
    logic [RR_W-1:0]         grant_idx;
    logic                    grant_any;
    logic                    alloc_en;
    int                      scan_idx;

    logic                    ret_ready;
    logic [PTR_W-1:0]        enq_off [RET_W];
    logic [PTR_W-1:0]        enq_run;
    logic [CNT_W-1:0]        enq_cnt;
    logic                    deq;
    logic                    flush_done;

    // Arbiter: first set request at or after rr_ptr, modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        alloc_en  = (state == RUN) && bus.fl_free_valid;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % N_REQ;
            if (alloc_en && !grant_any && bus.req[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                grant_idx       = RR_W'(scan_idx);
                grant_any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + RR_W'(1);
        end
    end

    assign bus.grant     = grant;
    assign bus.grant_tag = grant_any ? bus.fl_free_tag : '0;
    assign bus.fl_pop_en = grant_any;

    // Space check uses the registered count only, so ready never depends on this cycle's dequeue.
    assign ret_ready = (CNT_W'(RET_DEPTH) - count) >= CNT_W'(RET_W);
    assign deq       = (count != '0);

    // Each valid slot lands at wr_ptr plus the number of valid slots below it, so the FIFO has no holes.
    always_comb begin
        enq_run = '0;
        enq_cnt = '0;
        for (int i = 0; i < RET_W; i++) begin
            enq_off[i] = enq_run;
            if (ret_ready && bus.ret_valid[i]) begin
                enq_run = enq_run + PTR_W'(1);
                enq_cnt = enq_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < RET_W; i++) begin
            if (ret_ready && bus.ret_valid[i]) begin
                mem[wr_ptr + enq_off[i]] <= bus.ret_tag[i*PREG_IDX_W +: PREG_IDX_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count + enq_cnt - CNT_W'(deq);
            rd_ptr <= rd_ptr + PTR_W'(deq);
            wr_ptr <= wr_ptr + enq_cnt[PTR_W-1:0];
        end
    end

    assign bus.fl_retire_en  = deq;
    assign bus.fl_retire_tag = deq ? mem[rd_ptr] : '0;
    assign bus.ret_ready     = ret_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN:   if (bus.flush_req) state_nxt = DRAIN;
            // A retire arriving on the empty cycle keeps us draining.
            DRAIN: if (count == '0 && enq_cnt == '0) state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = bus.flush_req ? HOLD : RUN;
            end
            HOLD:  if (!bus.flush_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign bus.flush_done = flush_done;

`ifdef FL_SCHED_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_stalls;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (grant_any && stat_grants != 32'hFFFF_FFFF) begin
                stat_grants <= stat_grants + 32'd1;
            end
            if ((|bus.req) && !grant_any && stat_stalls != 32'hFFFF_FFFF) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end

    assign bus.stat_grants = stat_grants;
    assign bus.stat_stalls = stat_stalls;
`endif

    // Offering retire tags while not ready loses them.
    ret_overflow_a: assert property (@(posedge clock) disable iff (reset)
        !((|bus.ret_valid) && !ret_ready));

endmodule

// File: tb/tb_fl_alloc_sched.sv
// Directed bench for fl_alloc_sched: arbiter vector table, retire FIFO against a queue model,
// then flush and reset-during-drain sequences.
module tb_fl_alloc_sched;
    localparam int N_REQ      = 4;
    localparam int RET_W      = 2;
    localparam int RET_DEPTH  = 8;
    localparam int PREG_IDX_W = 6;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fl_alloc_sched_if #(.N_REQ(N_REQ), .RET_W(RET_W), .PREG_IDX_W(PREG_IDX_W)) bus ();

    fl_alloc_sched #(
        .N_REQ(N_REQ), .RET_W(RET_W), .RET_DEPTH(RET_DEPTH), .PREG_IDX_W(PREG_IDX_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] req;
        logic       fv;
        logic [5:0] tag;
        logic [3:0] exp_grant;
    } arb_vec_t;

    typedef struct {
        logic [1:0] vld;
        logic [5:0] t0;
        logic [5:0] t1;
    } ret_vec_t;

    int vec_cnt = 0;
    int err_cnt = 0;

    arb_vec_t   av [14];
    ret_vec_t   rv [10];
    logic [5:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ret(input logic [1:0] vld, input logic [5:0] t0, input logic [5:0] t1);
        bus.ret_valid = vld;
        bus.ret_tag   = {t1, t0};
    endtask

    initial begin
        // Arbiter table; rr_ptr evolution is noted per row.
        av[0]  = '{4'b1111, 1'b1, 6'd10, 4'b0001}; // rr 0 -> 1
        av[1]  = '{4'b1111, 1'b1, 6'd11, 4'b0010}; // -> 2
        av[2]  = '{4'b1111, 1'b1, 6'd12, 4'b0100}; // -> 3
        av[3]  = '{4'b1111, 1'b1, 6'd13, 4'b1000}; // -> 0
        av[4]  = '{4'b1111, 1'b1, 6'd14, 4'b0001}; // -> 1
        av[5]  = '{4'b1111, 1'b0, 6'd15, 4'b0000}; // no free tag, holds 1
        av[6]  = '{4'b1111, 1'b1, 6'd16, 4'b0010}; // -> 2
        av[7]  = '{4'b0011, 1'b1, 6'd17, 4'b0001}; // scan 2,3,0 -> 1
        av[8]  = '{4'b0011, 1'b1, 6'd18, 4'b0010}; // -> 2
        av[9]  = '{4'b0000, 1'b1, 6'd19, 4'b0000}; // holds 2
        av[10] = '{4'b1000, 1'b1, 6'd20, 4'b1000}; // -> 0
        av[11] = '{4'b0110, 1'b1, 6'd21, 4'b0010}; // -> 2
        av[12] = '{4'b0110, 1'b1, 6'd22, 4'b0100}; // -> 3
        av[13] = '{4'b0101, 1'b1, 6'd23, 4'b0001}; // scan 3,0 -> 1

        rv[0] = '{2'b11, 6'd7, 6'd9};
        rv[1] = '{2'b11, 6'd7, 6'd9};
        rv[2] = '{2'b11, 6'd7, 6'd9};
        rv[3] = '{2'b11, 6'd7, 6'd9};
        rv[4] = '{2'b11, 6'd7, 6'd9};
        rv[5] = '{2'b11, 6'd7, 6'd9};
        rv[6] = '{2'b10, 6'd5, 6'd33};
        rv[7] = '{2'b01, 6'd20, 6'd44};
        rv[8] = '{2'b11, 6'd7, 6'd9};
        rv[9] = '{2'b11, 6'd7, 6'd9};

        reset             = 1'b1;
        bus.req           = '0;
        bus.fl_free_valid = 1'b0;
        bus.fl_free_tag   = '0;
        bus.flush_req     = 1'b0;
        drive_ret(2'b00, 6'd0, 6'd0);

        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_pop", 32'(bus.fl_pop_en), 32'h0);
        chk("rst_retire_en", 32'(bus.fl_retire_en), 32'h0);
        chk("rst_flush_done", 32'(bus.flush_done), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_ret_ready", 32'(bus.ret_ready), 32'h1);

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            bus.req           = av[i].req;
            bus.fl_free_valid = av[i].fv;
            bus.fl_free_tag   = av[i].tag;
            #1;
            chk($sformatf("arb%0d_grant", i), 32'(bus.grant), 32'(av[i].exp_grant));
            chk($sformatf("arb%0d_pop", i), 32'(bus.fl_pop_en), 32'(|av[i].exp_grant));
            if (av[i].exp_grant != 4'b0000)
                chk($sformatf("arb%0d_tag", i), 32'(bus.grant_tag), 32'(av[i].tag));
        end

        // Retire FIFO: fill past ready threshold, mixed slot patterns, full drain.
        begin
            int p = 0;
            logic enq;
            @(negedge clock);
            bus.req = '0;
            for (int c = 0; c < 26; c++) begin
                if (c > 0) @(negedge clock);
                enq = ((RET_DEPTH - q.size()) >= RET_W) && (p < 10);
                if (enq) drive_ret(rv[p].vld, rv[p].t0, rv[p].t1);
                else     drive_ret(2'b00, 6'd0, 6'd0);
                #1;
                chk($sformatf("fifo%0d_ready", c), 32'(bus.ret_ready),
                    32'((RET_DEPTH - q.size()) >= RET_W));
                chk($sformatf("fifo%0d_en", c), 32'(bus.fl_retire_en), 32'(q.size() != 0));
                if (q.size() != 0)
                    chk($sformatf("fifo%0d_tag", c), 32'(bus.fl_retire_tag), 32'(q[0]));
                if (q.size() != 0) void'(q.pop_front());
                if (enq) begin
                    if (rv[p].vld[0]) q.push_back(rv[p].t0);
                    if (rv[p].vld[1]) q.push_back(rv[p].t1);
                    p++;
                end
            end
            chk("fifo_all_enqueued", 32'(p), 32'd10);
        end

        // Single slot-1 tag: not visible the same cycle, retired the next.
        @(negedge clock);
        drive_ret(2'b10, 6'd5, 6'd33);
        #1;
        chk("slot1_no_bypass", 32'(bus.fl_retire_en), 32'h0);
        @(negedge clock);
        drive_ret(2'b00, 6'd0, 6'd0);
        #1;
        chk("slot1_en", 32'(bus.fl_retire_en), 32'h1);
        chk("slot1_tag", 32'(bus.fl_retire_tag), 32'd33);
        @(negedge clock);
        #1;
        chk("slot1_single", 32'(bus.fl_retire_en), 32'h0);

        // Flush with three queued tags {9,7,9}; rr_ptr is 1 here.
        @(negedge clock);
        drive_ret(2'b11, 6'd7, 6'd9);
        @(negedge clock);
        drive_ret(2'b11, 6'd7, 6'd9);
        @(negedge clock);
        drive_ret(2'b00, 6'd0, 6'd0);
        bus.flush_req     = 1'b1;
        bus.req           = 4'b1111;
        bus.fl_free_valid = 1'b1;
        bus.fl_free_tag   = 6'd40;
        #1;
        chk("fl_c_grant", 32'(bus.grant), 32'h2);
        chk("fl_c_tag", 32'(bus.fl_retire_tag), 32'd9);
        @(negedge clock);
        #1;
        chk("fl_d_grant", 32'(bus.grant), 32'h0);
        chk("fl_d_pop", 32'(bus.fl_pop_en), 32'h0);
        chk("fl_d_tag", 32'(bus.fl_retire_tag), 32'd7);
        chk("fl_d_done", 32'(bus.flush_done), 32'h0);
        @(negedge clock);
        #1;
        chk("fl_e_tag", 32'(bus.fl_retire_tag), 32'd9);
        chk("fl_e_done", 32'(bus.flush_done), 32'h0);
        @(negedge clock);
        #1;
        chk("fl_f_en", 32'(bus.fl_retire_en), 32'h0);
        chk("fl_f_done", 32'(bus.flush_done), 32'h0);
        @(negedge clock);
        #1;
        chk("fl_g_done", 32'(bus.flush_done), 32'h1);
        chk("fl_g_grant", 32'(bus.grant), 32'h0);
        @(negedge clock);
        bus.flush_req = 1'b0;
        #1;
        chk("fl_h_hold_done", 32'(bus.flush_done), 32'h0);
        chk("fl_h_hold_grant", 32'(bus.grant), 32'h0);
        @(negedge clock);
        #1;
        chk("fl_i_run_grant", 32'(bus.grant), 32'h4);

        // Reset while draining.
        @(negedge clock);
        bus.req = '0;
        drive_ret(2'b11, 6'd3, 6'd4);
        @(negedge clock);
        drive_ret(2'b11, 6'd3, 6'd4);
        @(negedge clock);
        drive_ret(2'b00, 6'd0, 6'd0);
        bus.flush_req = 1'b1;
        @(negedge clock);
        #1;
        chk("rd_drain_en", 32'(bus.fl_retire_en), 32'h1);
        chk("rd_drain_grant", 32'(bus.grant), 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("rd_rst_en", 32'(bus.fl_retire_en), 32'h0);
        chk("rd_rst_ready", 32'(bus.ret_ready), 32'h1);
        @(negedge clock);
        reset         = 1'b0;
        bus.flush_req = 1'b0;
        bus.req       = 4'b1111;
        #1;
        chk("rd_run_grant", 32'(bus.grant), 32'h1);
        chk("rd_run_en", 32'(bus.fl_retire_en), 32'h0);
        @(negedge clock);
        #1;
        chk("rd_run_next", 32'(bus.grant), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
